// File: rtl/sqrt_share_arb.sv
// sqrt_share_arb: one multi-cycle restoring integer square-root engine shared
// by NREQ requesters under round-robin arbitration. Each accepted request
// returns floor(sqrt(radicand)) tagged with the requester index.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   req       per-requester request level
//   radicand  packed operands, requester i at [i*RAD_W +: RAD_W]
//   ack       one-hot accept pulse (combinational, IDLE only)
//   busy      engine occupied (CALC or DONE)
//   done_vld  one-cycle result strobe
//   done_id   requester index owning the result
//   root      floor(sqrt(radicand)), held until the next done_vld
module sqrt_share_arb #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned RAD_W  = 24,
  parameter int unsigned ROOT_W = 12,
  parameter int unsigned ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*RAD_W-1:0]  radicand,
  output logic [NREQ-1:0]        ack,
  output logic                   busy,
  output logic                   done_vld,
  output logic [ID_W-1:0]        done_id,
  output logic [ROOT_W-1:0]      root
);

  localparam int unsigned OP_W   = 2 * ROOT_W;
  localparam int unsigned REM_W  = ROOT_W + 2;
  localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);
  localparam int unsigned SCAN_W = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_id;
  logic [OP_W-1:0]     opnd;
  logic [REM_W-1:0]    rem;
  logic [ROOT_W-1:0]   root_part;
  logic [CNT_W-1:0]    cnt;

  logic                gnt_any;
  logic [ID_W-1:0]     gnt_idx;
  logic [SCAN_W-1:0]   scan;
  logic [RAD_W-1:0]    rad_sel;
  logic [REM_W-1:0]    rem_sh;
  logic [REM_W-1:0]    trial;
  logic [REM_W-1:0]    rem_nxt;
  logic [ROOT_W-1:0]   root_part_nxt;
  logic                last_step;

  // Round-robin search: first set req bit starting at rr_ptr, wrapping mod NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      scan = SCAN_W'(rr_ptr) + SCAN_W'(off);
      if (scan >= SCAN_W'(NREQ)) begin
        scan = scan - SCAN_W'(NREQ);
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!gnt_any && (scan == SCAN_W'(i)) && req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    rad_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        rad_sel = radicand[i*RAD_W +: RAD_W];
      end
    end
  end

  // One restoring step: bring in the next two operand bits, try {root,01}.
  always_comb begin
    rem_sh    = (rem << 2) | REM_W'(opnd[OP_W-1 -: 2]);
    trial     = {root_part, 2'b01};
    last_step = (cnt == CNT_W'(ROOT_W - 1));
    if (rem_sh >= trial) begin
      rem_nxt       = rem_sh - trial;
      root_part_nxt = (root_part << 1) | ROOT_W'(1'b1);
    end else begin
      rem_nxt       = rem_sh;
      root_part_nxt = root_part << 1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and grant strobe.
  always_comb begin
    state_nxt = state;
    ack       = '0;
    case (state)
      IDLE: begin
        if (gnt_any && !reset) begin
          state_nxt = CALC;
          for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = (gnt_idx == ID_W'(i));
          end
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done_vld <= 1'b0;
    end else begin
      busy     <= (state_nxt != IDLE);
      done_vld <= (state_nxt == DONE);
    end
  end

  // Datapath: operand capture, iteration registers, result and pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      opnd      <= '0;
      rem       <= '0;
      root_part <= '0;
      cnt       <= '0;
      done_id   <= '0;
      root      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            opnd      <= OP_W'(rad_sel);
            gnt_id    <= gnt_idx;
            rem       <= '0;
            root_part <= '0;
            cnt       <= '0;
          end
        end
        CALC: begin
          opnd      <= opnd << 2;
          rem       <= rem_nxt;
          root_part <= root_part_nxt;
          cnt       <= cnt + CNT_W'(1);
          // Publish the result as the engine enters DONE.
          if (last_step) begin
            root    <= root_part_nxt;
            done_id <= gnt_id;
          end
        end
        DONE: begin
          // The requester just served drops to lowest priority.
          if (gnt_id == ID_W'(NREQ - 1)) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= gnt_id + ID_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
